// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                         |
// | Brief   : Shared UART types/constants for the TX dump and RX paths.        |
// |           UART_TX_PARITY_EN adds the parity-bit state to the TX enum.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_W_DEFAULT = 128;
  localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE       = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY_BIT = 3'd3,
`endif
    TX_STOP_BIT   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    DUMP_IDLE   = 3'd0,
    DUMP_FETCH  = 3'd1,
    DUMP_SEND   = 3'd2,
    DUMP_DRAIN  = 3'd3,
    DUMP_FINISH = 3'd4
  } dump_state_e;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_mem_dump_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_mem_dump_tx_if                                              |
// | Brief   : Control, memory read port and serial line of the memory dumper.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface uart_mem_dump_tx_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       word_count;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] rd_data;
  logic              tx;
  logic              busy;
  logic              done;

  // Master is the requester/memory side, slave is the dumper.
  modport master (
    output start, base_addr, word_count, rd_data,
    input  read_addr, tx, busy, done
  );

  modport slave (
    input  start, base_addr, word_count, rd_data,
    output read_addr, tx, busy, done
  );
endinterface : uart_mem_dump_tx_if
`default_nettype wire

// File: rtl/uart_mem_dump_tx_byte_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_byte_tx                                                     |
// | Brief   : One-byte UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  wire        clk,
  input  wire        rst_n,
  input  wire        byte_valid,
  input  wire  [7:0] byte_data,
  output logic       byte_ready,
  output logic       idle,
  output logic       tx
);

  localparam int              c_baud_w    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

  tx_state_e           r_state;
  tx_state_e           w_next;
  logic [c_baud_w-1:0] r_baud;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                w_bit_end;
  logic                w_load;
`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif

  assign w_bit_end  = (r_baud == c_baud_last);
  // Accepting during the last stop-bit cycle keeps frames back-to-back.
  assign byte_ready = (r_state == TX_IDLE) || ((r_state == TX_STOP_BIT) && w_bit_end);
  assign w_load     = byte_valid && byte_ready;
  assign idle       = (r_state == TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TX_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE:      if (w_load) w_next = TX_START_BIT;
      TX_START_BIT: if (w_bit_end) w_next = TX_DATA_BITS;
      TX_DATA_BITS: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_next = TX_PARITY_BIT;
`else
          w_next = TX_STOP_BIT;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: if (w_bit_end) w_next = TX_STOP_BIT;
`endif
      TX_STOP_BIT:  if (w_bit_end) w_next = w_load ? TX_START_BIT : TX_IDLE;
      default:      w_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      if ((r_state == TX_IDLE) || w_bit_end) r_baud <= '0;
      else                                   r_baud <= r_baud + 1'b1;

      if (w_load) begin
        r_shift   <= byte_data;
        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity  <= ^byte_data;
`endif
      end else if ((r_state == TX_DATA_BITS) && w_bit_end) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    tx = UART_STOP_BIT;
    case (r_state)
      TX_START_BIT:  tx = UART_START_BIT;
      TX_DATA_BITS:  tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: tx = r_parity;
`endif
      default:       tx = UART_STOP_BIT;
    endcase
  end

endmodule : uart_byte_tx
`default_nettype wire

// File: rtl/uart_mem_dump_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_mem_dump_tx                                                 |
// | Brief   : Streams a range of memory words out of a UART, byte 0 first.     |
// |           UART_TX_PARITY_EN selects 8E1 framing in the byte transmitter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_mem_dump_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int READ_LAT     = 2,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 128
) (
  input wire                clk,
  input wire                rst_n,
  uart_mem_dump_tx_if.slave bus
);

  localparam int c_bytes = bytes_per_word(DATA_W);
  localparam int c_idx_w = $clog2(c_bytes + 1);
  localparam int c_lat_w = $clog2(READ_LAT + 2);

  dump_state_e         r_state;
  dump_state_e         w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_words_left;
  logic [DATA_W-1:0]   r_word;
  logic [c_idx_w-1:0]  r_byte_idx;
  logic [c_lat_w-1:0]  r_lat;
  logic                w_lat_done;
  logic                w_last_byte;
  logic                w_byte_valid;
  logic                w_byte_ready;
  logic                w_byte_idle;
  logic                w_accept;
  logic                w_more_words;
  logic                w_tx;

  assign w_lat_done   = (r_lat == c_lat_w'(READ_LAT));
  assign w_last_byte  = (r_byte_idx == c_idx_w'(c_bytes - 1));
  assign w_byte_valid = (r_state == DUMP_SEND);
  assign w_accept     = w_byte_valid && w_byte_ready;
  assign w_more_words = (r_words_left > 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DUMP_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DUMP_IDLE: begin
        if (bus.start) w_next = (bus.word_count == 16'd0) ? DUMP_FINISH : DUMP_FETCH;
      end
      DUMP_FETCH:  if (w_lat_done) w_next = DUMP_SEND;
      DUMP_SEND:   if (w_accept && w_last_byte) w_next = DUMP_DRAIN;
      // Wait for the last stop bit to leave the line before moving on.
      DUMP_DRAIN:  if (w_byte_idle) w_next = w_more_words ? DUMP_FETCH : DUMP_FINISH;
      DUMP_FINISH: w_next = DUMP_IDLE;
      default:     w_next = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_words_left <= '0;
      r_word       <= '0;
      r_byte_idx   <= '0;
      r_lat        <= '0;
    end else begin
      case (r_state)
        DUMP_IDLE: begin
          if (bus.start) begin
            r_addr       <= bus.base_addr;
            r_words_left <= bus.word_count;
            r_lat        <= '0;
          end
        end
        DUMP_FETCH: begin
          if (w_lat_done) begin
            r_word     <= bus.rd_data;
            r_byte_idx <= '0;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        DUMP_SEND: begin
          if (w_accept) begin
            r_word     <= {8'h00, r_word[DATA_W-1:8]};
            r_byte_idx <= r_byte_idx + 1'b1;
          end
        end
        DUMP_DRAIN: begin
          if (w_byte_idle && w_more_words) begin
            r_words_left <= r_words_left - 16'd1;
            r_addr       <= r_addr + 1'b1;
            r_lat        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (w_byte_valid),
    .byte_data  (r_word[7:0]),
    .byte_ready (w_byte_ready),
    .idle       (w_byte_idle),
    .tx         (w_tx)
  );

  assign bus.read_addr = r_addr;
  assign bus.tx        = w_tx;
  assign bus.busy      = (r_state != DUMP_IDLE);
  assign bus.done      = (r_state == DUMP_FINISH);

endmodule : uart_mem_dump_tx
`default_nettype wire

// File: tb/tb_uart_mem_dump_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_mem_dump_tx                                              |
// | Brief   : Directed bench for uart_mem_dump_tx with a 2-cycle memory model. |
// |           Honours UART_TX_PARITY_EN for 8E1 frames.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_mem_dump_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif
  localparam int RX_TIMEOUT = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   tx_low_seen = 1'b0;
  bit   log_en = 1'b0;
  logic [15:0] last_addr;
  logic [15:0] addr_q[$];
  logic [127:0] p1;

  uart_mem_dump_tx_if #(.ADDR_W(16), .DATA_W(128)) bus ();

  uart_mem_dump_tx #(
    .CLKS_PER_BIT (CPB),
    .READ_LAT     (2),
    .ADDR_W       (16),
    .DATA_W       (128)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte k of word a is (16*a + k) mod 256: mem[0x10] = 0F..0100.
  function automatic logic [7:0] exp_byte(input logic [15:0] a, input int k);
    int v;
    v = int'(a) * 16 + k;
    return v[7:0];
  endfunction

  function automatic logic [127:0] mem_word(input logic [15:0] a);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = exp_byte(a, k);
    return w;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1 <= mem_word(bus.read_addr);
    bus.rd_data <= p1;
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.tx === 1'b0) tx_low_seen <= 1'b1;
    if (log_en && bus.read_addr !== last_addr) begin
      addr_q.push_back(bus.read_addr);
      last_addr = bus.read_addr;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receives one frame sampling mid-bit; ok=0 on timeout or bad framing.
  task automatic rx_byte(output logic [7:0] b, output int t_start, output bit ok);
    int n;
    ok = 1'b1;
    b = 8'h00;
    n = 0;
    t_start = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx !== 1'b0 && n < RX_TIMEOUT);
    if (bus.tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t_start = cyc;
    repeat (CPB / 2) @(negedge clk);
    if (bus.tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = bus.tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (CPB) @(negedge clk);
    if (bus.tx !== ^b) ok = 1'b0;
`endif
    repeat (CPB) @(negedge clk);
    if (bus.tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic kick(input logic [15:0] base, input logic [15:0] count);
    @(negedge clk);
    bus.base_addr  = base;
    bus.word_count = count;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.base_addr = 16'h0;
    bus.word_count = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", bus.tx); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.read_addr !== 16'h0) begin fails++; $display("FAIL reset_addr got %h want 0000", bus.read_addr); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word;
    logic [7:0] b;
    int t, tprev, d0, n;
    bit ok;
    d0 = done_cnt;
    tprev = 0;
    kick(16'h0010, 16'd1);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_on got %b want 1", bus.busy); end
    for (int k = 0; k < 16; k++) begin
      rx_byte(b, t, ok);
      tests++;
      if (!ok || b !== k[7:0]) begin
        fails++; $display("FAIL single_byte%0d got %h ok=%0d want %h", k, b, ok, k[7:0]);
      end
      if (k > 0) begin
        tests++;
        if (t - tprev != FRAME) begin
          fails++; $display("FAIL single_spacing%0d got %0d want %0d", k, t - tprev, FRAME);
        end
      end
      tprev = t;
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_off got %b want 0", bus.busy); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL single_done_count got %0d want 1", done_cnt - d0); end
    tests++; if (bus.read_addr !== 16'h0010) begin fails++; $display("FAIL single_addr got %h want 0010", bus.read_addr); end
  endtask

  task automatic test_multi_wrap;
    logic [7:0] b;
    logic [7:0] e;
    int t, n;
    bit ok;
    addr_q.delete();
    last_addr = bus.read_addr;
    log_en = 1'b1;
    kick(16'hFFFF, 16'd2);
    for (int k = 0; k < 32; k++) begin
      rx_byte(b, t, ok);
      e = (k < 16) ? exp_byte(16'hFFFF, k) : exp_byte(16'h0000, k - 16);
      tests++;
      if (!ok || b !== e) begin
        fails++; $display("FAIL wrap_byte%0d got %h ok=%0d want %h", k, b, ok, e);
      end
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
    log_en = 1'b0;
    tests++;
    if (addr_q.size() != 2 || addr_q[0] !== 16'hFFFF || addr_q[1] !== 16'h0000) begin
      fails++; $display("FAIL wrap_addr_seq got size %0d first %h want FFFF,0000", addr_q.size(),
                        (addr_q.size() > 0) ? addr_q[0] : 16'hxxxx);
    end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL wrap_busy_off got %b want 0", bus.busy); end
  endtask

  task automatic test_count_zero;
    int d0;
    d0 = done_cnt;
    tx_low_seen = 1'b0;
    kick(16'h1234, 16'd0);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL zero_busy1 got %b want 1", bus.busy); end
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL zero_done1 got %b want 1", bus.done); end
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL zero_busy2 got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zero_done2 got %b want 0", bus.done); end
    repeat (10) @(negedge clk);
    tests++; if (tx_low_seen) begin fails++; $display("FAIL zero_tx_quiet got low want high"); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL zero_done_count got %0d want 1", done_cnt - d0); end
    tests++; if (bus.read_addr !== 16'h1234) begin fails++; $display("FAIL zero_addr got %h want 1234", bus.read_addr); end
  endtask

  task automatic test_ignore_start;
    logic [7:0] bytes[16];
    bit oks[16];
    int d0;
    bit seen_done;
    d0 = done_cnt;
    seen_done = 1'b0;
    kick(16'h0025, 16'd1);
    fork
      begin
        int t;
        for (int k = 0; k < 16; k++) rx_byte(bytes[k], t, oks[k]);
      end
      begin
        int n;
        repeat (100) @(negedge clk);
        bus.base_addr = 16'h0033; bus.word_count = 16'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        seen_done = (bus.done === 1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tx_low_seen = 1'b0;
      end
    join
    tests++; if (!seen_done) begin fails++; $display("FAIL ignore_done_seen got 0 want 1"); end
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (!oks[k] || bytes[k] !== exp_byte(16'h0025, k)) begin
        fails++; $display("FAIL ignore_byte%0d got %h ok=%0d want %h", k, bytes[k], oks[k], exp_byte(16'h0025, k));
      end
    end
    repeat (20) @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_busy got %b want 0", bus.busy); end
    tests++; if (tx_low_seen) begin fails++; $display("FAIL ignore_tx_quiet got low want high"); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL ignore_done_count got %0d want 1", done_cnt - d0); end
    tests++; if (bus.read_addr !== 16'h0025) begin fails++; $display("FAIL ignore_addr got %h want 0025", bus.read_addr); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int t, n, d0;
    bit ok;
    kick(16'h0007, 16'd1);
    for (int k = 0; k < 5; k++) rx_byte(b, t, ok);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.tx !== 1'b0 && n < RX_TIMEOUT);
    // Byte 5 is 8'h75: data bit 1 drives the line low.
    repeat (9) @(negedge clk);
    tests++; if (bus.tx !== 1'b0) begin fails++; $display("FAIL midrst_bit1 got %b want 0", bus.tx); end
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.tx !== 1'b1) begin fails++; $display("FAIL midrst_tx got %b want 1", bus.tx); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL midrst_no_done got %0d want %0d", done_cnt, d0); end
    kick(16'h0002, 16'd1);
    for (int k = 0; k < 16; k++) begin
      rx_byte(b, t, ok);
      tests++;
      if (!ok || b !== exp_byte(16'h0002, k)) begin
        fails++; $display("FAIL midrst_byte%0d got %h ok=%0d want %h", k, b, ok, exp_byte(16'h0002, k));
      end
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL midrst_done_after got %0d want 1", done_cnt - d0); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] b;
    int t, tprev;
    bit ok;
    tprev = 0;
    kick(16'h0000, 16'd1);
    for (int k = 0; k < 16; k++) begin
      rx_byte(b, t, ok);
      if (k == 3 || k == 7) begin
        tests++;
        if (!ok || b !== k[7:0]) begin
          fails++; $display("FAIL parity_byte%0d got %h ok=%0d want %h", k, b, ok, k[7:0]);
        end
      end
      if (k == 8) begin
        tests++;
        if (t - tprev != 44) begin fails++; $display("FAIL parity_frame got %0d want 44", t - tprev); end
      end
      tprev = t;
    end
    repeat (20) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_multi_wrap();
    test_count_zero();
    test_ignore_start();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_mem_dump_tx
`default_nettype wire
